// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit for the EX stage. It owns HI/LO.
// Results are computed at issue, held, and committed when the busy countdown expires.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MdOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi, r_lo;
  logic [31:0] r_res_hi, r_res_lo;
  logic        r_commit;

  logic               w_accept;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic               w_neg_a, w_neg_b;
  logic [31:0]        w_mag_a, w_mag_b, w_dvs;
  logic [31:0]        w_quo_u, w_rem_u, w_quo, w_rem;

  assign w_accept = start & ~flush & (r_state == S_IDLE);

  assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide works on magnitudes; quotient sign is the XOR of operand
  // signs, remainder follows the dividend. 0x80000000/-1 falls out as 0x80000000 r 0.
  assign w_neg_a = (MdOp == OP_DIV) & A[31];
  assign w_neg_b = (MdOp == OP_DIV) & B[31];
  assign w_mag_a = w_neg_a ? (~A + 32'd1) : A;
  assign w_mag_b = w_neg_b ? (~B + 32'd1) : B;
  assign w_dvs   = (B == 32'd0) ? 32'd1 : w_mag_b;
  assign w_quo_u = w_mag_a / w_dvs;
  assign w_rem_u = w_mag_a % w_dvs;
  assign w_quo   = (w_neg_a ^ w_neg_b) ? (~w_quo_u + 32'd1) : w_quo_u;
  assign w_rem   = w_neg_a ? (~w_rem_u + 32'd1) : w_rem_u;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
      r_commit <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (MdOp)
              OP_MULT: begin
                {r_res_hi, r_res_lo} <= w_prod_s;
                r_commit <= 1'b1;
                r_cnt    <= MULT_LOAD;
                r_state  <= S_RUN;
              end
              OP_MULTU: begin
                {r_res_hi, r_res_lo} <= w_prod_u;
                r_commit <= 1'b1;
                r_cnt    <= MULT_LOAD;
                r_state  <= S_RUN;
              end
              OP_DIV, OP_DIVU: begin
                r_res_hi <= w_rem;
                r_res_lo <= w_quo;
                // Divide by zero still occupies the full period but never commits
                r_commit <= (B != 32'd0);
                r_cnt    <= DIV_LOAD;
                r_state  <= S_RUN;
              end
              OP_MTHI: r_hi <= A;
              OP_MTLO: r_lo <= A;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (r_cnt == 5'd0) begin
            r_state <= S_IDLE;
            if (r_commit) begin
              r_hi <= r_res_hi;
              r_lo <= r_res_lo;
            end
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  MdOp;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] m_hi, m_lo;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .MdOp(MdOp), .A(A), .B(B),
    .flush(flush), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV '/' truncates toward zero and '%' follows the dividend.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, b,
                                input logic [31:0] hi_in, lo_in,
                                output logic [31:0] hi_o, output logic [31:0] lo_o);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    hi_o = hi_in; lo_o = lo_in;
    case (op)
      3'd0: begin p = sa * sb; hi_o = p[63:32]; lo_o = p[31:0]; end
      3'd1: begin p = ua * ub; hi_o = p[63:32]; lo_o = p[31:0]; end
      3'd2: if (b != 0) begin lo_o = 32'(sa / sb); hi_o = 32'(sa % sb); end
      3'd3: if (b != 0) begin lo_o = a / b; hi_o = a % b; end
      3'd4: hi_o = a;
      3'd5: lo_o = a;
      default: ;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 once the unit is idle again.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, b, input bit fl);
    logic [31:0] eh, el;
    int exp_n, cnt;
    if (fl) begin eh = m_hi; el = m_lo; exp_n = 0; end
    else begin
      model(op, a, b, m_hi, m_lo, eh, el);
      exp_n = (op < 3'd2) ? MC : (op < 3'd4) ? DC : 0;
    end
    start = 1'b1; MdOp = op; A = a; B = b; flush = fl;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0; A = $urandom; B = $urandom; MdOp = 3'($urandom);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      chk({tag, "_hold_hi"}, HI, m_hi);
      chk({tag, "_hold_lo"}, LO, m_lo);
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_busy_len"}, cnt, exp_n);
    chk({tag, "_hi"}, HI, eh);
    chk({tag, "_lo"}, LO, el);
    m_hi = eh; m_lo = el;
  endtask

  initial begin
    int cnt;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bit          rfl;
    reset = 1'b1; start = 1'b0; flush = 1'b0; MdOp = 3'd0; A = '0; B = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);

    run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("mult_neg_hi_const", HI, 32'hFFFF_FFFF);
    chk("mult_neg_lo_const", LO, 32'hFFFF_FFFA);
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu_hi_const", HI, 32'hFFFF_FFFE);
    chk("multu_lo_const", LO, 32'h0000_0001);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_neg_lo_const", LO, 32'hFFFF_FFFD);
    chk("div_neg_hi_const", HI, 32'hFFFF_FFFF);
    run_op("divu", 3'd3, 32'd7, 32'd2, 1'b0);
    chk("divu_lo_const", LO, 32'd3);
    chk("divu_hi_const", HI, 32'd1);
    run_op("mthi11", 3'd4, 32'h11, 32'd0, 1'b0);
    run_op("mtlo22", 3'd5, 32'h22, 32'd0, 1'b0);
    run_op("div_by0", 3'd2, 32'd5, 32'd0, 1'b0);
    run_op("divu_by0", 3'd3, 32'd9, 32'd0, 1'b0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_ovf_lo_const", LO, 32'h8000_0000);
    chk("div_ovf_hi_const", HI, 32'd0);
    run_op("mthi_abcd", 3'd4, 32'hABCD, 32'd0, 1'b0);
    run_op("flush_mult", 3'd0, 32'd1234, 32'd5678, 1'b1);
    run_op("nop6", 3'd6, 32'd1, 32'd2, 1'b0);
    run_op("nop7", 3'd7, 32'd1, 32'd2, 1'b0);

    // mtlo while busy is ignored; flush while busy does not cancel
    begin
      logic [31:0] eh, el;
      model(3'd0, 32'd100, 32'd7, m_hi, m_lo, eh, el);
      start = 1'b1; MdOp = 3'd0; A = 32'd100; B = 32'd7;
      @(posedge clk); #1;
      MdOp = 3'd5; A = 32'h999;
      cnt = 0;
      while (busy === 1'b1 && cnt < 40) begin
        chk("busy_ops_hold_lo", LO, m_lo);
        @(posedge clk); #1;
        if (cnt == 0) begin start = 1'b0; flush = 1'b1; end
        else flush = 1'b0;
        cnt++;
      end
      start = 1'b0; flush = 1'b0;
      chk("busy_ops_len", cnt, MC);
      chk("busy_ops_hi", HI, eh);
      chk("busy_ops_lo", LO, el);
      m_hi = eh; m_lo = el;
    end

    // Reset mid-operation discards the pending result
    start = 1'b1; MdOp = 3'd3; A = 32'd1000; B = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", HI, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    repeat (DC + 2) @(posedge clk);
    #1;
    chk("midrst_late_hi", HI, 32'd0);
    chk("midrst_late_lo", LO, 32'd0);
    chk("midrst_late_busy", {31'd0, busy}, 32'd0);
    m_hi = '0; m_lo = '0;

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      rfl = ($urandom_range(0, 7) == 0);
      run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, rfl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
